// File: rtl/dsp_equation_scheduler.sv
// Job FIFO and launch sequencer for the shared DSP equation engine.
// Launches one job at a time and tracks done/error/timeout.
module dsp_equation_scheduler #(
  parameter int EQ_W  = 8,
  parameter int TO_W  = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [EQ_W-1:0]  cmd_equation,
  input  logic [TO_W-1:0]  cmd_timeout,
  input  logic             abort,
  input  logic             irq_clear,
  input  logic             equation_done,
  input  logic             equation_error,
  output logic [EQ_W-1:0]  equation_number,
  output logic             equation_start,
  output logic             busy,
  output logic [LVL_W-1:0] queue_level,
  output logic [15:0]      done_count,
  output logic             status_error,
  output logic             status_timeout,
  output logic             interrupt
);

  localparam int PW = LVL_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    FINISH,
    FAULT
  } state_t;

  state_t state, state_nx;

  logic [EQ_W-1:0]  mem_eq [DEPTH];
  logic [TO_W-1:0]  mem_to [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_idx;
  logic [LVL_W-1:0] count;
  logic [TO_W-1:0]  timer;
  logic             push, pop;
  logic             run_hold;
  logic             set_err, set_to, set_irq;

  assign cmd_ready   = (count < LVL_W'(DEPTH));
  assign queue_level = count;
  assign push        = cmd_valid & cmd_ready;
  // abort cancels any pop offered in the same cycle
  assign pop         = (state == IDLE) & (count != '0) & ~abort;
  assign wr_idx      = abort ? '0 : wr_ptr;

  assign busy           = (state != IDLE);
  assign equation_start = (state == LAUNCH);

  // RUN cycle with no terminating event: timer keeps counting
  assign run_hold = (state == RUN) & ~equation_done
                  & ~equation_error & ~abort;
  assign set_err  = (state == RUN) & ~equation_done & equation_error;
  assign set_to   = run_hold & (timer == TO_W'(1));
  assign set_irq  = (state == FINISH) | (state == FAULT);

  always_ff @(posedge wb_clk) begin
    if (push) begin
      mem_eq[wr_idx] <= cmd_equation;
      mem_to[wr_idx] <= cmd_timeout;
    end
  end

  // A push accepted alongside abort lands in the freshly flushed FIFO
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      count  <= push ? LVL_W'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (pop) state_nx = LAUNCH;
      LAUNCH: state_nx = RUN;
      RUN: begin
        if (equation_done)       state_nx = FINISH;
        else if (equation_error) state_nx = FAULT;
        else if (abort)          state_nx = FAULT;
        else if (set_to)         state_nx = FAULT;
      end
      FINISH: state_nx = IDLE;
      FAULT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      equation_number <= '0;
      timer           <= '0;
    end else if (pop) begin
      equation_number <= mem_eq[rd_ptr];
      timer           <= mem_to[rd_ptr];
    end else if (set_irq) begin
      equation_number <= '0;
      timer           <= '0;
    end else if (run_hold && timer > TO_W'(1)) begin
      timer <= timer - 1'b1;
    end
  end

  // set events take precedence over irq_clear
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      done_count     <= '0;
      status_error   <= 1'b0;
      status_timeout <= 1'b0;
      interrupt      <= 1'b0;
    end else begin
      if (state == FINISH) done_count <= done_count + 1'b1;

      if (set_err)        status_error <= 1'b1;
      else if (irq_clear) status_error <= 1'b0;

      if (set_to)         status_timeout <= 1'b1;
      else if (irq_clear) status_timeout <= 1'b0;

      if (set_irq)        interrupt <= 1'b1;
      else if (irq_clear) interrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_equation_scheduler.sv
// Randomized bench for dsp_equation_scheduler with a job-level
// reference model and a scripted engine responder.
module tb_dsp_equation_scheduler;

  localparam int EQ_W  = 8;
  localparam int TO_W  = 16;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  localparam int M_DONE  = 0;
  localparam int M_ERR   = 1;
  localparam int M_NEVER = 2;
  localparam int M_BOTH  = 3;
  localparam int M_ABORT = 4;
  localparam int M_RESET = 5;

  logic             wb_clk;
  logic             wb_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [EQ_W-1:0]  cmd_equation;
  logic [TO_W-1:0]  cmd_timeout;
  logic             abort;
  logic             irq_clear;
  logic             equation_done;
  logic             equation_error;
  logic [EQ_W-1:0]  equation_number;
  logic             equation_start;
  logic             busy;
  logic [LVL_W-1:0] queue_level;
  logic [15:0]      done_count;
  logic             status_error;
  logic             status_timeout;
  logic             interrupt;

  dsp_equation_scheduler #(
    .EQ_W (EQ_W),
    .TO_W (TO_W),
    .DEPTH(DEPTH),
    .LVL_W(LVL_W)
  ) dut (
    .wb_clk         (wb_clk),
    .wb_rst         (wb_rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_equation   (cmd_equation),
    .cmd_timeout    (cmd_timeout),
    .abort          (abort),
    .irq_clear      (irq_clear),
    .equation_done  (equation_done),
    .equation_error (equation_error),
    .equation_number(equation_number),
    .equation_start (equation_start),
    .busy           (busy),
    .queue_level    (queue_level),
    .done_count     (done_count),
    .status_error   (status_error),
    .status_timeout (status_timeout),
    .interrupt      (interrupt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [7:0] eq;
    int         to;
    int         mode;
    int         d;
  } job_t;

  job_t job_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int exp_count   = 0;
  bit exp_err     = 0;
  bit exp_to      = 0;
  bit exp_irq     = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_job(input logic [7:0] eq, input int to,
                          input int mode, input int d);
    job_t j;
    int   n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge wb_clk); #1;
      n++;
    end
    check("push_ready", cmd_ready, 1);
    j.eq = eq; j.to = to; j.mode = mode; j.d = d;
    job_q.push_back(j);
    cmd_valid    = 1'b1;
    cmd_equation = eq;
    cmd_timeout  = TO_W'(to);
    @(posedge wb_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, done_count, exp_count[15:0]);
    check({tag, "_err"}, status_error, exp_err);
    check({tag, "_to"}, status_timeout, exp_to);
    check({tag, "_irq"}, interrupt, exp_irq);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!(busy == 1'b0 && queue_level == '0) && n < 1000);
    check({tag, "_idle"}, (busy == 1'b0 && queue_level == '0), 1);
    check_model(tag);
    @(posedge wb_clk); #1;
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    @(posedge wb_clk); #1;
    irq_clear = 1'b0;
    exp_err = 0; exp_to = 0; exp_irq = 0;
    check_model("irqclr");
  endtask

  // engine responder: drives done/error/abort per the job's script
  initial begin : engine
    job_t j;
    bit   tmo;
    int   c_end;
    equation_done  = 1'b0;
    equation_error = 1'b0;
    abort          = 1'b0;
    forever begin
      @(negedge wb_clk);
      if (equation_start === 1'b1 && wb_rst === 1'b0) begin
        check("start_expected", job_q.size() > 0, 1);
        if (job_q.size() > 0) begin
          j = job_q.pop_front();
          check("launch_eq", equation_number, j.eq);
          check("launch_busy", busy, 1);
          if (j.mode == M_RESET) begin
            repeat (j.d) @(posedge wb_clk);
          end else begin
            tmo = (j.to > 0) && (j.mode == M_NEVER || j.d > j.to);
            c_end = tmo ? j.to : j.d;
            for (int c = 1; c <= c_end; c++) begin
              @(posedge wb_clk); #1;
              if (c == c_end && !tmo) begin
                if (j.mode == M_DONE || j.mode == M_BOTH)
                  equation_done = 1'b1;
                if (j.mode == M_ERR || j.mode == M_BOTH)
                  equation_error = 1'b1;
                if (j.mode == M_ABORT) begin
                  abort = 1'b1;
                  job_q.delete();
                end
              end
            end
            @(negedge wb_clk);
            check("last_run_eq", equation_number, j.eq);
            check_model("pre");
            exp_irq = 1;
            if (tmo) exp_to = 1;
            else if (j.mode == M_DONE || j.mode == M_BOTH)
              exp_count = (exp_count + 1) & 16'hFFFF;
            else if (j.mode == M_ERR) exp_err = 1;
            @(posedge wb_clk); #1;
            equation_done  = 1'b0;
            equation_error = 1'b0;
            abort          = 1'b0;
            @(posedge wb_clk);
            @(negedge wb_clk);
            check("gap_eq", equation_number, 0);
            check("gap_start", equation_start, 0);
            check_model("post");
            if (j.mode == M_ABORT && !tmo)
              check("abort_level", queue_level, 0);
          end
        end
      end
    end
  end

  initial begin : main
    int   nj;
    int   to;
    int   mode;
    logic [7:0] eq;
    wb_rst       = 1'b1;
    cmd_valid    = 1'b0;
    cmd_equation = '0;
    cmd_timeout  = '0;
    irq_clear    = 1'b0;
    #1;
    check("rst_eq", equation_number, 0);
    check("rst_start", equation_start, 0);
    check("rst_busy", busy, 0);
    check("rst_level", queue_level, 0);
    check_model("rst");
    repeat (2) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    @(posedge wb_clk); #1;

    // single job with start latency
    push_job(8'd1, 0, M_DONE, 5);
    @(negedge wb_clk);
    check("lat_n1_start", equation_start, 0);
    @(negedge wb_clk);
    check("lat_n2_start", equation_start, 1);
    wait_idle("single");

    // queue fill while a long job runs
    push_job(8'h11, 0, M_DONE, 14);
    for (int i = 0; i < 4; i++)
      push_job(8'h21 + 8'(i), 0, M_DONE, 2);
    check("full_level", queue_level, DEPTH);
    check("full_ready", cmd_ready, 0);
    push_job(8'h31, 0, M_DONE, 2);
    wait_idle("fill");

    // timeout
    push_job(8'd2, 10, M_NEVER, 0);
    wait_idle("timeout");

    // done and error together: done wins
    clear_irq();
    push_job(8'd3, 0, M_BOTH, 3);
    wait_idle("prio");

    // abort with jobs queued behind
    clear_irq();
    push_job(8'd4, 0, M_ABORT, 3);
    push_job(8'd5, 0, M_DONE, 2);
    push_job(8'd6, 0, M_DONE, 2);
    wait_idle("abort");

    // randomized batches
    for (int b = 0; b < 30; b++) begin
      nj = $urandom_range(1, 3);
      for (int k = 0; k < nj; k++) begin
        eq   = 8'($urandom_range(1, 255));
        to   = $urandom_range(0, 8);
        mode = $urandom_range(0, 4);
        if (mode == M_NEVER && to == 0) to = $urandom_range(1, 8);
        push_job(eq, to, mode, $urandom_range(1, 10));
      end
      wait_idle("rand");
      if ($urandom_range(0, 2) == 0) clear_irq();
    end

    // asynchronous reset in the middle of RUN
    push_job(8'd7, 0, M_RESET, 2);
    repeat (4) @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    exp_count = 0; exp_err = 0; exp_to = 0; exp_irq = 0;
    job_q.delete();
    check("mrst_eq", equation_number, 0);
    check("mrst_busy", busy, 0);
    check("mrst_start", equation_start, 0);
    check_model("mrst");
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
    push_job(8'd9, 0, M_DONE, 3);
    wait_idle("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_equation_scheduler.md
Name: dsp_equation_scheduler

Overview:
Sequences jobs onto the shared DSP equation engine block (sum/multiply selected by equation number).
- Software or upstream logic queues jobs of {equation number, timeout}.
- The scheduler launches them one at a time by driving the equation-number field and a start pulse.
- It watches done/error, enforces a per-job timeout, and reports status and a sticky interrupt.
- It sits between the wishbone register slave and the equations top.

Parameters:
EQ_W, 8, width of equation-number field
TO_W, 16, width of timeout counter
DEPTH, 4, job FIFO entries (power of 2, >=2)
LVL_W, 3, width of queue_level (clog2(DEPTH)+1)

Ports:
wb_clk  input  1  clock
wb_rst  input  1  asynchronous active-high reset
cmd_valid  input  1  job offered
cmd_ready  output  1  FIFO can accept job
cmd_equation  input  EQ_W  equation number of job (nonzero)
cmd_timeout  input  TO_W  max RUN cycles; 0 = no timeout
abort  input  1  kill running job and flush FIFO
irq_clear  input  1  clear interrupt and sticky flags
equation_done  input  1  level done from equations top
equation_error  input  1  level error from equations top
equation_number  output  EQ_W  drives equation-number field; 0 = none selected
equation_start  output  1  one-cycle launch pulse
busy  output  1  FSM not IDLE
queue_level  output  LVL_W  FIFO occupancy
done_count  output  16  completed-job counter
status_error  output  1  sticky: a job ended on equation_error
status_timeout  output  1  sticky: a job timed out
interrupt  output  1  sticky completion/fault interrupt

Behaviour:
- Reset (async, wb_rst=1): all outputs 0, FIFO empty, FSM IDLE, timer 0. Reset mid-job drops the job with no status update.
- FIFO:
  - cmd_ready = (queue_level < DEPTH), combinational from count.
  - Push on cmd_valid & cmd_ready; no push while full.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, RUN, FINISH, FAULT.
  - IDLE: if FIFO nonempty, pop; latch equation_number and timer=cmd_timeout; go LAUNCH. Else equation_number=0.
  - LAUNCH: equation_start=1 for exactly this cycle; go RUN.
  - RUN, checked in priority order:
    - equation_done=1 -> FINISH (done wins over error/timeout/abort in the same cycle).
    - else equation_error=1 -> FAULT with status_error set.
    - else abort=1 -> FAULT; flush FIFO; no sticky flag.
    - else timer==1 with a nonzero timeout loaded -> FAULT with status_timeout set.
    - else, if a timeout is set, decrement timer.
  - FINISH: done_count+1 (wraps at 0xFFFF); interrupt set; equation_number cleared to 0; go IDLE.
  - FAULT: interrupt set; equation_number cleared to 0; go IDLE.
- Engine deselect: equation_number is 0 for at least one cycle between jobs, so a held done deasserts before the next launch.
- Latency: a job pushed at edge N into an empty FIFO with FSM IDLE pops at N+1 and asserts equation_start during cycle N+2.
- Timeout: with cmd_timeout=T>0, FAULT is entered when done has not been seen within T cycles of RUN.
- abort outside RUN: flushes the FIFO only. abort in IDLE on the same cycle as a pop: flush wins and the pop is cancelled.
- irq_clear: clears interrupt, status_error and status_timeout. A set event in the same cycle wins.
- busy = (state != IDLE).

Test Plan:
- Single job: push eq=1, to=0. Engine asserts done 5 cycles after start -> start pulse 2 cycles after push; FINISH; done_count=1; interrupt=1; equation_number 1 -> 0.
- Queue fill: 5 back-to-back pushes with DEPTH=4 while a job runs -> cmd_ready=0 at queue_level=4; jobs launched in FIFO order; equation_number=0 for at least one cycle between jobs.
- Timeout: push eq=2, to=10, never assert done -> status_timeout=1 and interrupt=1 after 10 RUN cycles; done_count unchanged.
- Priority: equation_done and equation_error both assert in the same RUN cycle -> FINISH; status_error=0; done_count+1.
- Abort: 3 jobs queued, abort pulsed mid-RUN -> FAULT; queue_level=0; no further start pulses; interrupt=1; no sticky flag.
- Reset mid-RUN: wb_rst asserted -> all outputs 0 immediately (async); after release, a new job is accepted and starts normally.
